// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock controller.
// Also holds the minute-addition helper used by the ALARM_SNOOZE_EN snooze path.
package alarm_clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  SEC_MAX  = 6'd59;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'b00,
    MODE_SET_TIME  = 2'b01,
    MODE_SET_ALARM = 2'b10
  } mode_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } hm_t;

  // Adds k minutes (k <= 59) with carry into the hour, wrapping at midnight.
  function automatic hm_t add_minutes(input hm_t t, input logic [MIN_W-1:0] k);
    logic [MIN_W:0] sum;
    hm_t            r;
    sum = {1'b0, t.min} + {1'b0, k};
    r   = t;
    if (sum > {1'b0, MIN_MAX}) begin
      r.min  = MIN_W'(sum - 7'd60);
      r.hour = (t.hour == HOUR_MAX) ? '0 : t.hour + 5'd1;
    end else begin
      r.min = sum[MIN_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/clock_time_counter.sv
// HH:MM:SS time-of-day registers with a tick carry chain and manual field increments.
// zero_sec pulses for one cycle after a tick rolls seconds over to zero.
module clock_time_counter
  import alarm_clock_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_en,
  input  logic              inc_hour,
  input  logic              inc_min,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  min,
  output logic [MIN_W-1:0]  sec,
  output logic              zero_sec
);

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hour     <= '0;
      min      <= '0;
      sec      <= '0;
      zero_sec <= 1'b0;
    end else begin
      zero_sec <= 1'b0;
      if (tick_en) begin
        if (sec == SEC_MAX) begin
          sec      <= '0;
          zero_sec <= 1'b1;
          if (min == MIN_MAX) begin
            min  <= '0;
            hour <= (hour == HOUR_MAX) ? '0 : hour + 5'd1;
          end else begin
            min <= min + 6'd1;
          end
        end else begin
          sec <= sec + 6'd1;
        end
      end else begin
        // Manual edits never carry and never raise zero_sec, so they cannot ring.
        if (inc_hour) hour <= (hour == HOUR_MAX) ? '0 : hour + 5'd1;
        if (inc_min) begin
          min <= (min == MIN_MAX) ? '0 : min + 6'd1;
          sec <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// Alarm clock sequencer: mode FSM, alarm registers, ring control and display mux.
// Define ALARM_SNOOZE_EN to build the snooze target registers and btn_snooze handling.
module alarm_clock_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_MIN     = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_hour,
  input  logic              btn_min,
  input  logic              btn_alarm,
  input  logic              btn_snooze,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min,
  output logic [MIN_W-1:0]  disp_sec,
  output logic [1:0]        mode,
  output logic              alarm_armed,
  output logic              alarm_ring,
  output logic              blink
);

  localparam logic [7:0] RING_LIMIT = 8'(RING_TIMEOUT_S);

  mode_e             mode_q, mode_d;
  logic [HOUR_W-1:0] t_hour, al_hour, cmp_hour;
  logic [MIN_W-1:0]  t_min, t_sec, al_min, cmp_min;
  logic              zero_sec, tick_en, set_hour, set_min, al_inc_hour, al_inc_min;
  logic              armed_q, ring_q, blink_q, match_hit, ring_start, snooze_req;
  logic [7:0]        ring_cnt;

  // NOTE: mode_d gets its default first so no path through the case leaves it unassigned.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:       if (btn_mode) mode_d = MODE_SET_TIME;
      MODE_SET_TIME:  if (btn_mode) mode_d = MODE_SET_ALARM;
      MODE_SET_ALARM: if (btn_mode) mode_d = MODE_RUN;
      default:        mode_d = MODE_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_RUN;
      blink_q <= 1'b1;
    end else begin
      mode_q <= mode_d;
      if (mode_d != mode_q || mode_q == MODE_RUN) blink_q <= 1'b1;
      else if (tick_1hz)                          blink_q <= ~blink_q;
    end
  end

  // A mode change in the same cycle suppresses the field buttons.
  assign tick_en     = tick_1hz && (mode_q != MODE_SET_TIME);
  assign set_hour    = btn_hour && !btn_mode && (mode_q == MODE_SET_TIME);
  assign set_min     = btn_min  && !btn_mode && (mode_q == MODE_SET_TIME);
  assign al_inc_hour = btn_hour && !btn_mode && (mode_q == MODE_SET_ALARM);
  assign al_inc_min  = btn_min  && !btn_mode && (mode_q == MODE_SET_ALARM);

  clock_time_counter u_time (
    .clk      (clk),
    .rst      (rst),
    .tick_en  (tick_en),
    .inc_hour (set_hour),
    .inc_min  (set_min),
    .hour     (t_hour),
    .min      (t_min),
    .sec      (t_sec),
    .zero_sec (zero_sec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      al_hour <= '0;
      al_min  <= '0;
    end else begin
      if (al_inc_hour) al_hour <= (al_hour == HOUR_MAX) ? '0 : al_hour + 5'd1;
      if (al_inc_min)  al_min  <= (al_min  == MIN_MAX)  ? '0 : al_min + 6'd1;
    end
  end

`ifdef ALARM_SNOOZE_EN
  logic snz_pend;
  hm_t  snz_tgt;

  assign snooze_req = btn_snooze && ring_q && !btn_alarm;
  assign cmp_hour   = snz_pend ? snz_tgt.hour : al_hour;
  assign cmp_min    = snz_pend ? snz_tgt.min  : al_min;

  always_ff @(posedge clk) begin
    if (rst) begin
      snz_pend <= 1'b0;
      snz_tgt  <= '0;
    end else if ((btn_alarm && !ring_q && armed_q) || al_inc_hour || al_inc_min) begin
      snz_pend <= 1'b0;
    end else if (snooze_req) begin
      snz_pend <= 1'b1;
      snz_tgt  <= add_minutes('{hour: t_hour, min: t_min}, MIN_W'(SNOOZE_MIN));
    end else if (ring_start) begin
      snz_pend <= 1'b0;
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = btn_snooze;
  assign snooze_req    = 1'b0;
  assign cmp_hour      = al_hour;
  assign cmp_min       = al_min;
`endif

  assign match_hit  = zero_sec && armed_q && (mode_q != MODE_SET_TIME) &&
                      (t_hour == cmp_hour) && (t_min == cmp_min);
  assign ring_start = !btn_alarm && !snooze_req && !ring_q && match_hit;

  // btn_alarm outranks snooze, which outranks the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q  <= 1'b0;
      ring_q   <= 1'b0;
      ring_cnt <= '0;
    end else if (btn_alarm) begin
      if (ring_q) begin
        ring_q   <= 1'b0;
        armed_q  <= 1'b0;
        ring_cnt <= '0;
      end else begin
        armed_q <= ~armed_q;
      end
    end else if (snooze_req) begin
      ring_q   <= 1'b0;
      ring_cnt <= '0;
    end else if (ring_q) begin
      if (tick_1hz) begin
        if (ring_cnt == RING_LIMIT - 8'd1) begin
          ring_q   <= 1'b0;
          ring_cnt <= '0;
        end else begin
          ring_cnt <= ring_cnt + 8'd1;
        end
      end
    end else if (ring_start) begin
      ring_q   <= 1'b1;
      ring_cnt <= '0;
    end
  end

  assign disp_hour   = (mode_q == MODE_SET_ALARM) ? al_hour : t_hour;
  assign disp_min    = (mode_q == MODE_SET_ALARM) ? al_min  : t_min;
  assign disp_sec    = (mode_q == MODE_SET_ALARM) ? '0      : t_sec;
  assign mode        = mode_q;
  assign alarm_armed = armed_q;
  assign alarm_ring  = ring_q;
  assign blink       = blink_q;

endmodule

// File: doc/alarm_clock_ctrl.md
Name: alarm_clock_ctrl

Overview:
- Timekeeping and user-interface sequencer for the digital alarm clock.
- Keeps HH:MM:SS in binary from a 1 Hz tick pulse supplied by the upstream prescaler.
- Runs a mode FSM (run / set time / set alarm) driven by pre-debounced single-cycle button pulses.
- Compares time against the stored alarm, drives the ring output, and feeds the display/7-seg encoder downstream.

Parameters:
- RING_TIMEOUT_S, 60, ticks the ring stays active before auto-silencing (1..255).
- SNOOZE_MIN, 9, minutes added to current time on snooze (1..59).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous to clk, active high
- tick_1hz  in  1  one-cycle pulse, once per second
- btn_mode  in  1  one-cycle pulse: advance mode
- btn_hour  in  1  one-cycle pulse: increment hour field
- btn_min  in  1  one-cycle pulse: increment minute field
- btn_alarm  in  1  one-cycle pulse: toggle alarm armed; silences ring
- btn_snooze  in  1  one-cycle pulse: snooze (used only with ALARM_SNOOZE_EN)
- disp_hour  out  5  displayed hour, 0..23
- disp_min  out  6  displayed minute, 0..59
- disp_sec  out  6  displayed second, 0..59 (0 in SET_ALARM)
- mode  out  2  00 RUN, 01 SET_TIME, 10 SET_ALARM
- alarm_armed  out  1  alarm enabled
- alarm_ring  out  1  buzzer drive
- blink  out  1  display blink enable for set modes

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset (rst=1 at a clk edge) gives: time 00:00:00, alarm 00:00, mode=RUN, alarm_armed=0, alarm_ring=0, blink=1, snooze pending=0, ring counter=0. Reset mid-operation aborts everything the same edge.
- All outputs are registered or derived from registers; no combinational input-to-output paths.
- FSM transitions on btn_mode: RUN->SET_TIME->SET_ALARM->RUN; illegal code 11 -> RUN next cycle.
- If btn_mode fires together with btn_hour/btn_min, the mode change wins and the field buttons are ignored that cycle.
- Timekeeping, RUN and SET_ALARM:
  - tick advances sec; 59->0 carries into min; min 59->0 carries into hour; hour 23->0.
  - 23:59:59 + tick = 00:00:00. Time is updated on the same edge as the tick.
- SET_TIME:
  - tick is ignored (time frozen).
  - btn_hour: hour+1 mod 24.
  - btn_min: min+1 mod 60, sec cleared to 0, no carry into hour.
  - btn_hour and btn_min in the same cycle: both apply.
- SET_ALARM: btn_hour/btn_min edit alarm hour/min with the same wrap rules and no carry; any edit clears a pending snooze.
- RUN: btn_hour/btn_min are ignored.
- Display mux: disp_* shows time in RUN/SET_TIME and alarm (sec=0) in SET_ALARM.
- blink: 1 in RUN; in set modes it toggles on each tick; it is forced to 1 on entry to any mode.
- Alarm match:
  - Condition: alarm_armed=1, mode!=SET_TIME, and a tick-driven update produces sec=0 with hour:min equal to the alarm (or to the snooze target when a snooze is pending).
  - Effect: alarm_ring=1 one cycle after the time update edge.
  - Manual time setting never triggers a ring.
  - A snooze match clears the pending snooze.
- Ring termination:
  - btn_alarm while ringing: ring=0 and alarm_armed toggles to 0.
  - btn_alarm while not ringing: toggles armed; disarming also clears any pending snooze.
  - Auto-stop: the ring counter increments per tick while ringing; when it reaches RING_TIMEOUT_S, ring=0, armed unchanged, counter cleared.
  - If btn_alarm and the timeout occur in the same cycle, btn_alarm takes effect.

Optional Feature:
ALARM_SNOOZE_EN
- Defined: btn_snooze while alarm_ring=1 clears ring and sets snooze target = current hour:min + SNOOZE_MIN, with carry into hour and mod 24. A later match on the target re-rings.
- btn_snooze while not ringing: ignored.
- btn_snooze together with btn_alarm: btn_alarm wins.
- Not defined: btn_snooze is ignored (tied into an unused sink); snooze registers do not exist.

Decomposition:
- Package alarm_clock_pkg holds:
  - mode enum (MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM)
  - constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59
  - width constants HOUR_W=5, MIN_W=6
- Sub-module clock_time_counter: HH:MM:SS registers with tick/carry chain, set-hour/set-min inputs, and a rollover-to-zero-second strobe. Instantiated once.
- Alarm registers, FSM, ring and snooze logic live in the top.

Test Plan:
- Reset, then 3725 ticks in RUN -> time 01:02:05; preload 23:59:59 + 1 tick -> 00:00:00, no spurious ring.
- btn_mode x1; btn_hour x25, btn_min x61 -> 01:01:00, ticks ignored (sec stays 0); btn_mode x2 -> mode=RUN.
- Alarm set 06:30 via SET_ALARM; armed; time preloaded 06:29:58 -> alarm_ring=1 one cycle after the tick giving 06:30:00; stays 1 for 60 ticks then 0, armed still 1.
- Ringing + btn_alarm -> ring=0, armed=0; setting time to 06:30 in SET_TIME -> no ring.
- ALARM_SNOOZE_EN: alarm 23:55, snooze at 23:55:10 -> ring=0; re-ring at 00:04:00; without the macro the same stimulus leaves ring=1 until the timeout.
- btn_mode and btn_hour in the same cycle from RUN -> mode=SET_TIME, hour unchanged; rst pulse while ringing -> all reset values on the next edge.
